// File: rtl/acc64_stream.sv
// acc64_stream: streaming 64-bit accumulator with a valid/ready operand
// port and a valid/ready result port.
// Each accepted beat is added using a 32/32 carry-select adder.
// Optional feature macro: ACC64_SAT_EN. When it is defined, the accumulator
// saturates to all-ones on any carry-out.
module acc64_stream #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_t           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [63:0]      acc_cur_s;
  logic             carry_cur_s;
  logic [CNT_W-1:0] cnt_cur_s;
  logic [64:0]      sum_s;
  logic [63:0]      acc_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             accept_s;
  logic             close_s;

  // Carry-select add. The low half uses a carry-in of 0. The high half is
  // computed for both carry-in values, and the low-half carry picks one.
  // The result is {carry_out, sum[63:0]}.
  function automatic logic [64:0] csa_add64(input logic [63:0] a, input logic [63:0] b);
    logic [32:0] lo;
    logic [32:0] hi0;
    logic [32:0] hi1;
    logic [32:0] hi;
    lo  = {1'b0, a[31:0]} + {1'b0, b[31:0]};
    hi0 = {1'b0, a[63:32]} + {1'b0, b[63:32]};
    hi1 = {1'b0, a[63:32]} + {1'b0, b[63:32]} + 33'd1;
    hi  = lo[32] ? hi1 : hi0;
    return {hi, lo[31:0]};
  endfunction

  // Datapath: select the frame-start operands, add, and decide whether the beat closes the frame.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_cur_s   = 64'd0;
      carry_cur_s = 1'b0;
      cnt_cur_s   = '0;
    end else begin
      acc_cur_s   = acc_q;
      carry_cur_s = carry_q;
      cnt_cur_s   = cnt_q;
    end
    sum_s     = csa_add64(acc_cur_s, in_data);
    cnt_inc_s = cnt_cur_s + CNT_W'(1);
    accept_s  = in_valid && in_ready_q;
    close_s   = in_last || (cnt_inc_s == LEN_C);
`ifdef ACC64_SAT_EN
    if (sum_s[64]) begin
      acc_nxt_s = {64{1'b1}};
    end else begin
      acc_nxt_s = sum_s[63:0];
    end
`else
    acc_nxt_s = sum_s[63:0];
`endif
  end

  // Next-state and next-output logic. Every register holds its value by default.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_count_d = out_count_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept_s) begin
          acc_d   = acc_nxt_s;
          carry_d = carry_cur_s | sum_s[64];
          cnt_d   = cnt_inc_s;
          if (close_s) begin
            state_d     = S_HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_sum_d   = acc_nxt_s;
            out_carry_d = carry_cur_s | sum_s[64];
            out_count_d = cnt_inc_s;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          acc_d       = 64'd0;
          carry_d     = 1'b0;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_d       = 64'd0;
        carry_d     = 1'b0;
        cnt_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 64'd0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= 64'd0;
      out_carry_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_count = out_count_q;

endmodule
